eth_cmd_rx: RTL and testbench

ETH_CMD_RX -- requirements
Module: eth_cmd_rx

---
 rtl/eth_cmd_rx.sv | 181 ++++++++++++++++++
 tb/tb_eth_cmd_rx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_cmd_rx.sv
// Ethernet command receiver: parses a byte stream of command frames and applies
// register writes to the TDS readout configuration outputs.
module eth_cmd_rx #(
    parameter logic [47:0] MY_MAC          = 48'h000A35000001,
    parameter logic [15:0] ETHERTYPE       = 16'h88B5,
    parameter logic [11:0] COUNTER_TH_INIT = 12'd100,
    parameter logic [11:0] IDLE_TH_INIT    = 12'd1000,
    parameter int          RESET_PULSE_LEN = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_axis_fifo_tdata,
    input  logic        rx_axis_fifo_tvalid,
    input  logic        rx_axis_fifo_tlast,
    output logic        rx_axis_fifo_tready,
    output logic        soft_reset,
    output logic        tds_mode,
    output logic [3:0]  enable,
    output logic        debug_enable,
    output logic [11:0] counter_th,
    output logic [11:0] idle_counter_number_th,
    output logic [47:0] D_MAC_add,
    output logic [47:0] S_MAC_add,
    output logic        cmd_done,
    output logic [15:0] good_cmd_count,
    output logic [15:0] bad_frame_count
);

    localparam logic [47:0] BCAST_MAC    = '1;
    localparam logic [7:0]  OP_WRITE     = 8'h01;
    localparam logic [7:0]  PULSE_RELOAD = 8'(RESET_PULSE_LEN - 1);

    typedef enum logic [1:0] {HDR, CMD, DRAIN, COMMIT} state_t;
    typedef enum logic [1:0] {V_DROP, V_BAD, V_GOOD} verdict_t;

    state_t      state;
    verdict_t    verdict;
    logic [4:0]  byte_idx;
    logic [39:0] dst_head;
    logic        dst_ok;
    logic [7:0]  type_hi;
    logic [7:0]  opcode;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [7:0]  pulse_cnt;

    logic        beat;
    logic        last_beat;
    logic        hdr_pass;
    logic        commit_now;
    logic        bad_now;
    logic [31:0] word_now;

    assign rx_axis_fifo_tready = 1'b1;
    assign beat      = rx_axis_fifo_tvalid;
    assign last_beat = rx_axis_fifo_tvalid && rx_axis_fifo_tlast;
    assign hdr_pass  = dst_ok && ({type_hi, rx_axis_fifo_tdata} == ETHERTYPE);
    // When tlast lands on byte 19 the data word is still missing its LSB.
    assign word_now  = (state == CMD) ? {data[23:0], rx_axis_fifo_tdata} : data;

    // Frame verdict is resolved on the tlast beat so the commit lands one cycle later.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        commit_now = 1'b0;
        bad_now    = 1'b0;
        if (last_beat) begin
            unique case (state)
                HDR, COMMIT: bad_now = (byte_idx == 5'd13) && hdr_pass;
                CMD: begin
                    commit_now = (byte_idx == 5'd19) && (opcode == OP_WRITE);
                    bad_now    = !commit_now;
                end
                DRAIN: begin
                    commit_now = (verdict == V_GOOD);
                    bad_now    = (verdict == V_BAD);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= HDR;
            verdict                <= V_DROP;
            byte_idx               <= '0;
            dst_head               <= '0;
            dst_ok                 <= 1'b0;
            type_hi                <= '0;
            opcode                 <= '0;
            addr                   <= '0;
            data                   <= '0;
            pulse_cnt              <= '0;
            soft_reset             <= 1'b0;
            tds_mode               <= 1'b0;
            enable                 <= '0;
            debug_enable           <= 1'b0;
            counter_th             <= COUNTER_TH_INIT;
            idle_counter_number_th <= IDLE_TH_INIT;
            D_MAC_add              <= BCAST_MAC;
            S_MAC_add              <= MY_MAC;
            cmd_done               <= 1'b0;
            good_cmd_count         <= '0;
            bad_frame_count        <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment; later writes in this block win.
            cmd_done <= 1'b0;
            if (pulse_cnt != 8'd0) pulse_cnt <= pulse_cnt - 8'd1;
            else                   soft_reset <= 1'b0;

            if (state == COMMIT) state <= HDR;

            if (beat) begin
                unique case (state)
                    // COMMIT lasts one cycle; a beat arriving then is byte 0 of the next frame.
                    HDR, COMMIT: begin
                        if (byte_idx < 5'd5)   dst_head <= {dst_head[31:0], rx_axis_fifo_tdata};
                        if (byte_idx == 5'd5)  dst_ok   <= ({dst_head, rx_axis_fifo_tdata} == MY_MAC) ||
                                                           ({dst_head, rx_axis_fifo_tdata} == BCAST_MAC);
                        if (byte_idx == 5'd12) type_hi  <= rx_axis_fifo_tdata;
                        if (rx_axis_fifo_tlast) begin
                            state    <= HDR;
                            byte_idx <= '0;
                        end else if (byte_idx == 5'd13) begin
                            state    <= hdr_pass ? CMD : DRAIN;
                            verdict  <= V_DROP;
                            byte_idx <= 5'd14;
                        end else begin
                            state    <= HDR;
                            byte_idx <= byte_idx + 5'd1;
                        end
                    end
                    CMD: begin
                        if (byte_idx == 5'd14) opcode <= rx_axis_fifo_tdata;
                        if (byte_idx == 5'd15) addr   <= rx_axis_fifo_tdata;
                        if (byte_idx >= 5'd16) data   <= {data[23:0], rx_axis_fifo_tdata};
                        if (rx_axis_fifo_tlast) begin
                            state    <= HDR;
                            byte_idx <= '0;
                        end else if (byte_idx == 5'd19) begin
                            state   <= DRAIN;
                            verdict <= (opcode == OP_WRITE) ? V_GOOD : V_BAD;
                        end else begin
                            byte_idx <= byte_idx + 5'd1;
                        end
                    end
                    DRAIN: begin
                        if (rx_axis_fifo_tlast) begin
                            state    <= HDR;
                            byte_idx <= '0;
                        end
                    end
                endcase
            end

            if (bad_now) bad_frame_count <= bad_frame_count + 16'd1;

            if (commit_now) begin
                state          <= COMMIT;
                cmd_done       <= 1'b1;
                good_cmd_count <= good_cmd_count + 16'd1;
                case (addr)
                    8'h00: if (word_now[0]) begin
                        soft_reset <= 1'b1;
                        pulse_cnt  <= PULSE_RELOAD;
                    end
                    8'h01: tds_mode               <= word_now[0];
                    8'h02: enable                 <= word_now[3:0];
                    8'h03: debug_enable           <= word_now[0];
                    8'h04: counter_th             <= word_now[11:0];
                    8'h05: idle_counter_number_th <= word_now[11:0];
                    8'h06: D_MAC_add[47:32]       <= word_now[15:0];
                    8'h07: D_MAC_add[31:0]        <= word_now;
                    8'h08: S_MAC_add[47:32]       <= word_now[15:0];
                    8'h09: S_MAC_add[31:0]        <= word_now;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_cmd_rx.sv
// Directed plus randomized frames against a frame-level reference model of eth_cmd_rx.
// A second instance with a longer soft_reset pulse shows the mid-pulse restart.
module tb_eth_cmd_rx;

    localparam logic [47:0] MY_MAC = 48'h000A35000001;
    localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;
    localparam logic [15:0] ETYPE  = 16'h88B5;
    localparam int          LONG_PULSE = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tlast;

    logic        tready, soft_rst, tds_mode, debug_en, cmd_done;
    logic [3:0]  enable;
    logic [11:0] counter_th, idle_th;
    logic [47:0] d_mac, s_mac;
    logic [15:0] good_cnt, bad_cnt;

    logic        u2_tready, u2_soft_rst, u2_tds_mode, u2_debug_en, u2_cmd_done;
    logic [3:0]  u2_enable;
    logic [11:0] u2_counter_th, u2_idle_th;
    logic [47:0] u2_d_mac, u2_s_mac;
    logic [15:0] u2_good_cnt, u2_bad_cnt;

    eth_cmd_rx dut (
        .clk(clk), .reset(reset),
        .rx_axis_fifo_tdata(tdata), .rx_axis_fifo_tvalid(tvalid), .rx_axis_fifo_tlast(tlast),
        .rx_axis_fifo_tready(tready), .soft_reset(soft_rst), .tds_mode(tds_mode),
        .enable(enable), .debug_enable(debug_en), .counter_th(counter_th),
        .idle_counter_number_th(idle_th), .D_MAC_add(d_mac), .S_MAC_add(s_mac),
        .cmd_done(cmd_done), .good_cmd_count(good_cnt), .bad_frame_count(bad_cnt)
    );

    eth_cmd_rx #(.RESET_PULSE_LEN(LONG_PULSE)) dut_long (
        .clk(clk), .reset(reset),
        .rx_axis_fifo_tdata(tdata), .rx_axis_fifo_tvalid(tvalid), .rx_axis_fifo_tlast(tlast),
        .rx_axis_fifo_tready(u2_tready), .soft_reset(u2_soft_rst), .tds_mode(u2_tds_mode),
        .enable(u2_enable), .debug_enable(u2_debug_en), .counter_th(u2_counter_th),
        .idle_counter_number_th(u2_idle_th), .D_MAC_add(u2_d_mac), .S_MAC_add(u2_s_mac),
        .cmd_done(u2_cmd_done), .good_cmd_count(u2_good_cnt), .bad_frame_count(u2_bad_cnt)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [7:0]  frame[$];
    logic        m_tds, m_dbg;
    logic [3:0]  m_en;
    logic [11:0] m_cth, m_ith;
    logic [47:0] m_dmac, m_smac;
    logic [15:0] m_good, m_bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tds = 1'b0; m_dbg = 1'b0; m_en = '0;
        m_cth = 12'd100; m_ith = 12'd1000;
        m_dmac = BCAST; m_smac = MY_MAC;
        m_good = '0; m_bad = '0;
    endtask

    // Returns 0 = filtered out, 1 = bad frame, 2 = applied command.
    function automatic int model_frame();
        logic [47:0] dst;
        logic [15:0] et;
        logic [31:0] dat;
        if (frame.size() < 14) return 0;
        dst = {frame[0], frame[1], frame[2], frame[3], frame[4], frame[5]};
        et  = {frame[12], frame[13]};
        if ((dst != MY_MAC && dst != BCAST) || et != ETYPE) return 0;
        if (frame.size() < 20 || frame[14] != 8'h01) begin
            m_bad = m_bad + 16'd1;
            return 1;
        end
        dat = {frame[16], frame[17], frame[18], frame[19]};
        case (frame[15])
            8'h01: m_tds = dat[0];
            8'h02: m_en = dat[3:0];
            8'h03: m_dbg = dat[0];
            8'h04: m_cth = dat[11:0];
            8'h05: m_ith = dat[11:0];
            8'h06: m_dmac[47:32] = dat[15:0];
            8'h07: m_dmac[31:0] = dat;
            8'h08: m_smac[47:32] = dat[15:0];
            8'h09: m_smac[31:0] = dat;
            default: ;
        endcase
        m_good = m_good + 16'd1;
        return 2;
    endfunction

    task automatic build_frame(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] op,
                               input logic [7:0] ad, input logic [31:0] dat, input int len);
        logic [7:0] b;
        frame.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 6)        b = dst[47 - 8*i -: 8];
            else if (i < 12)  b = 8'(8'hC0 + i);
            else if (i == 12) b = et[15:8];
            else if (i == 13) b = et[7:0];
            else if (i == 14) b = op;
            else if (i == 15) b = ad;
            else if (i < 20)  b = dat[31 - 8*(i-16) -: 8];
            else              b = 8'($urandom);
            frame.push_back(b);
        end
    endtask

    // Leaves the caller 1 time unit after the clock edge that consumed tlast.
    task automatic send_frame(input int gap);
        for (int i = 0; i < frame.size(); i++) begin
            if (i > 0) repeat (gap) begin
                @(negedge clk); tvalid = 1'b0; tlast = 1'b0;
            end
            @(negedge clk);
            tdata = frame[i]; tvalid = 1'b1; tlast = (i == frame.size() - 1);
        end
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic check_regs(input string tag, input logic exp_done);
        check({tag, "/cmd_done"}, cmd_done, exp_done);
        check({tag, "/tds_mode"}, tds_mode, m_tds);
        check({tag, "/enable"}, enable, m_en);
        check({tag, "/debug_enable"}, debug_en, m_dbg);
        check({tag, "/counter_th"}, counter_th, m_cth);
        check({tag, "/idle_th"}, idle_th, m_ith);
        check({tag, "/D_MAC_add"}, d_mac, m_dmac);
        check({tag, "/S_MAC_add"}, s_mac, m_smac);
        check({tag, "/good_cnt"}, good_cnt, m_good);
        check({tag, "/bad_cnt"}, bad_cnt, m_bad);
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        check({tag, "/cmd_done_clear"}, cmd_done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v;
        int c1, c2;
        reset = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_regs("reset", 1'b0);
        check("reset/soft_reset", soft_rst, 1'b0);
        check("reset/tready", tready, 1'b1);
        @(negedge clk); reset = 1'b0;

        // Basic write to enable.
        build_frame(MY_MAC, ETYPE, 8'h01, 8'h02, 32'h0000000A, 20);
        v = model_frame(); send_frame(0);
        check_regs("basic", v == 2);
        check("basic/enable_A", enable, 4'hA);
        idle_check("basic");

        // Same frame with 3-cycle gaps and 10 padding bytes.
        build_frame(MY_MAC, ETYPE, 8'h01, 8'h02, 32'h0000000A, 30);
        v = model_frame(); send_frame(3);
        check_regs("gapped", v == 2);
        check("gapped/good_cnt_2", good_cnt, 16'd2);
        idle_check("gapped");

        // Broadcast soft reset, then an identical frame back-to-back while the long pulse runs.
        build_frame(BCAST, ETYPE, 8'h01, 8'h00, 32'h00000001, 20);
        v = model_frame(); send_frame(0);
        check_regs("srst1", v == 2);
        check("srst1/soft_reset", soft_rst, 1'b1);
        check("srst1/long_soft_reset", u2_soft_rst, 1'b1);
        v = model_frame(); send_frame(0);
        check_regs("srst2", v == 2);
        c1 = soft_rst ? 1 : 0;
        c2 = u2_soft_rst ? 1 : 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (soft_rst) c1++;
            if (u2_soft_rst) c2++;
        end
        check("srst/pulse_len", c1, 16);
        check("srst/restart_len", c2, LONG_PULSE);

        // Short frame and wrong opcode are bad frames.
        build_frame(MY_MAC, ETYPE, 8'h01, 8'h02, 32'h00000005, 18);
        v = model_frame(); send_frame(0);
        check_regs("short", v == 2);
        check("short/bad_cnt_1", bad_cnt, 16'd1);
        build_frame(MY_MAC, ETYPE, 8'h02, 8'h02, 32'h00000005, 20);
        v = model_frame(); send_frame(1);
        check_regs("bad_op", v == 2);
        check("bad_op/bad_cnt_2", bad_cnt, 16'd2);

        // Filtered frames followed back-to-back by a valid one.
        build_frame(48'h001122334455, ETYPE, 8'h01, 8'h02, 32'h00000003, 20);
        v = model_frame(); send_frame(0);
        check_regs("wrong_dst", v == 2);
        build_frame(MY_MAC, 16'h0800, 8'h01, 8'h02, 32'h00000003, 24);
        v = model_frame(); send_frame(0);
        check_regs("wrong_type", v == 2);
        build_frame(MY_MAC, ETYPE, 8'h01, 8'h08, 32'h00001234, 20);
        v = model_frame(); send_frame(0);
        check_regs("after_filter", v == 2);
        check("after_filter/S_MAC_hi", s_mac[47:32], 16'h1234);

        // Randomized frames, some back-to-back.
        for (int n = 0; n < 40; n++) begin
            logic [63:0] r;
            logic [47:0] dst;
            int sel, len, gap;
            r = {$urandom, $urandom};
            sel = $urandom_range(0, 9);
            dst = (sel < 5) ? MY_MAC : (sel < 7) ? BCAST : r[47:0];
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 19) : $urandom_range(20, 28);
            gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            build_frame(dst, ($urandom_range(0, 7) == 0) ? 16'h0800 : ETYPE,
                        ($urandom_range(0, 7) == 0) ? 8'h02 : 8'h01,
                        8'($urandom_range(1, 12)), $urandom, len);
            v = model_frame(); send_frame(gap);
            check_regs($sformatf("rnd%0d", n), v == 2);
            if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", n));
        end

        // Start a pulse, then reset in the middle of the next frame.
        build_frame(MY_MAC, ETYPE, 8'h01, 8'h00, 32'h00000001, 20);
        v = model_frame(); send_frame(0);
        check_regs("pre_reset", v == 2);
        build_frame(MY_MAC, ETYPE, 8'h01, 8'h01, 32'h00000001, 20);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); tdata = frame[i]; tvalid = 1'b1; tlast = 1'b0;
        end
        @(negedge clk); tdata = frame[10]; reset = 1'b1;
        @(posedge clk); #1;
        model_reset();
        check_regs("mid_reset", 1'b0);
        check("mid_reset/soft_reset", soft_rst, 1'b0);
        check("mid_reset/long_soft_reset", u2_soft_rst, 1'b0);
        @(negedge clk); reset = 1'b0; tvalid = 1'b0;

        build_frame(MY_MAC, ETYPE, 8'h01, 8'h05, 32'h00000123, 20);
        v = model_frame(); send_frame(0);
        check_regs("post_reset", v == 2);
        check("post_reset/idle_th", idle_th, 12'h123);
        idle_check("post_reset");

        // The long-pulse instance saw the same traffic, so its registers match the model.
        check("long/tready", u2_tready, 1'b1);
        check("long/cmd_done", u2_cmd_done, 1'b0);
        check("long/tds_mode", u2_tds_mode, m_tds);
        check("long/enable", u2_enable, m_en);
        check("long/debug_enable", u2_debug_en, m_dbg);
        check("long/counter_th", u2_counter_th, m_cth);
        check("long/idle_th", u2_idle_th, m_ith);
        check("long/D_MAC_add", u2_d_mac, m_dmac);
        check("long/S_MAC_add", u2_s_mac, m_smac);
        check("long/good_cnt", u2_good_cnt, m_good);
        check("long/bad_cnt", u2_bad_cnt, m_bad);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
